// File: rtl/ripple_carry_adder_4bit_if.sv
// ripple_carry_adder_4bit_if
//   Operand/result bundle for ripple_carry_adder_4bit.
//   Optional feature macro: RCA4_OVF_FLAG_EN (adds ovf_q).
//   Signals:
//     a, b    operands (unsigned or two's complement)
//     Cin     carry into bit 0
//     en      register-stage load enable
//     sum     combinational sum a+b+Cin
//     Cout    combinational carry out of the top bit
//     sum_q   registered sum
//     cout_q  registered carry out
//     ovf_q   registered signed-overflow flag (RCA4_OVF_FLAG_EN only)
//   Modports: master drives operands and observes results; slave is the adder.
interface ripple_carry_adder_4bit_if #(
   parameter int unsigned WIDTH = 4
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             Cin;
   logic             en;
   logic [WIDTH-1:0] sum;
   logic             Cout;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
`ifdef RCA4_OVF_FLAG_EN
   logic             ovf_q;

   modport master (
      output a, b, Cin, en,
      input  sum, Cout, sum_q, cout_q, ovf_q
   );

   modport slave (
      input  a, b, Cin, en,
      output sum, Cout, sum_q, cout_q, ovf_q
   );
`else
   modport master (
      output a, b, Cin, en,
      input  sum, Cout, sum_q, cout_q
   );

   modport slave (
      input  a, b, Cin, en,
      output sum, Cout, sum_q, cout_q
   );
`endif
endinterface

// File: rtl/ripple_carry_adder_4bit.sv
// ripple_carry_adder_4bit
//   Ripple-carry adder built from a chain of 1-bit full-adder cells, with a
//   combinational result and an enable-gated output register stage.
//   Optional feature macro: RCA4_OVF_FLAG_EN adds the registered
//   signed-overflow flag ovf_q; without it the overflow logic is absent.
//   Ports:
//     clk    rising-edge clock for the output register stage
//     rst_n  asynchronous active-low reset, clears the registered outputs
//     bus    ripple_carry_adder_4bit_if.slave (a, b, Cin, en in;
//            sum, Cout, sum_q, cout_q[, ovf_q] out)
//   Only WIDTH = 4 is supported.

// rca4_full_adder_cell
//   One bit of the carry chain.
//   Ports: x, y operand bits; ci carry in; s sum bit; co carry out.
module rca4_full_adder_cell (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);
   logic p;

   assign p  = x ^ y;
   assign s  = p ^ ci;
   assign co = (x & y) | (ci & p);
endmodule

module ripple_carry_adder_4bit #(
   parameter int unsigned WIDTH = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   ripple_carry_adder_4bit_if.slave        bus
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] s;
   // carry[i] is the carry into cell i; carry[WIDTH] leaves the top cell.
   logic [WIDTH:0]   carry;

   assign a        = bus.a;
   assign b        = bus.b;
   assign carry[0] = bus.Cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      rca4_full_adder_cell u_cell (
         .x  (a[i]),
         .y  (b[i]),
         .ci (carry[i]),
         .s  (s[i]),
         .co (carry[i+1])
      );
   end

   assign bus.sum  = s;
   assign bus.Cout = carry[WIDTH];

`ifdef RCA4_OVF_FLAG_EN
   logic ovf;

   // Signed overflow: carry into the sign bit differs from carry out of it.
   assign ovf = carry[WIDTH-1] ^ carry[WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.sum_q  <= '0;
         bus.cout_q <= 1'b0;
         bus.ovf_q  <= 1'b0;
      end else if (bus.en) begin
         bus.sum_q  <= s;
         bus.cout_q <= carry[WIDTH];
         bus.ovf_q  <= ovf;
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.sum_q  <= '0;
         bus.cout_q <= 1'b0;
      end else if (bus.en) begin
         bus.sum_q  <= s;
         bus.cout_q <= carry[WIDTH];
      end
   end
`endif
endmodule

// File: tb/tb_ripple_carry_adder_4bit.sv
// tb_ripple_carry_adder_4bit
//   Directed and exhaustive checks of ripple_carry_adder_4bit: combinational
//   sum/carry, register load/hold, asynchronous reset and, when
//   RCA4_OVF_FLAG_EN is defined, the registered signed-overflow flag.
module tb_ripple_carry_adder_4bit;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   ripple_carry_adder_4bit_if #(.WIDTH(4)) bus ();

   ripple_carry_adder_4bit #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_ovf(input string tag, input logic exp);
`ifdef RCA4_OVF_FLAG_EN
      check(tag, {7'd0, bus.ovf_q}, {7'd0, exp});
`else
      if (exp === 1'bx) $display("unreachable %s", tag);
`endif
   endtask

   // Drive a vector at the falling edge with en=1, check the combinational
   // result, then check the registered copy one rising edge later.
   task automatic apply(input string tag, input logic [3:0] va, input logic [3:0] vb,
                        input logic vc, input logic [3:0] es, input logic ec,
                        input logic eo);
      @(negedge clk);
      bus.a = va; bus.b = vb; bus.Cin = vc; bus.en = 1'b1;
      #1;
      check({tag, "_sum"},  {4'd0, bus.sum},   {4'd0, es});
      check({tag, "_cout"}, {7'd0, bus.Cout},  {7'd0, ec});
      @(posedge clk);
      #1;
      check({tag, "_sum_q"},  {4'd0, bus.sum_q},  {4'd0, es});
      check({tag, "_cout_q"}, {7'd0, bus.cout_q}, {7'd0, ec});
      check_ovf({tag, "_ovf_q"}, eo);
   endtask

   function automatic int sval(input logic [3:0] v);
      return v[3] ? int'(v) - 16 : int'(v);
   endfunction

   initial begin
      rst_n = 1'b0;
      bus.a = 4'b0110; bus.b = 4'b1100; bus.Cin = 1'b0; bus.en = 1'b0;
      #2;
      check("rst_sum_q",  {4'd0, bus.sum_q},  8'h00);
      check("rst_cout_q", {7'd0, bus.cout_q}, 8'h00);
      check_ovf("rst_ovf_q", 1'b0);
      check("rst_comb_sum",  {4'd0, bus.sum}, 8'h02);
      check("rst_comb_cout", {7'd0, bus.Cout}, 8'h01);

      // Reset held across an en=1 edge keeps the registers clear.
      bus.en = 1'b1;
      @(posedge clk);
      #1;
      check("rst_en_sum_q",  {4'd0, bus.sum_q},  8'h00);
      check("rst_en_cout_q", {7'd0, bus.cout_q}, 8'h00);

      @(negedge clk);
      rst_n = 1'b1;

      apply("v028",  4'b0110, 4'b1100, 1'b0, 4'b0010, 1'b1, 1'b0);
      apply("v029",  4'b1101, 4'b1001, 1'b1, 4'b0111, 1'b1, 1'b1);
      apply("v030a", 4'b0101, 4'b0011, 1'b1, 4'b1001, 1'b0, 1'b1);
      apply("v030b", 4'b0010, 4'b0011, 1'b0, 4'b0101, 1'b0, 1'b0);
      apply("v031a", 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
      apply("v031b", 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);
      apply("v029r", 4'b1101, 4'b1001, 1'b1, 4'b0111, 1'b1, 1'b1);

      // Hold with en=0 while inputs change.
      @(negedge clk);
      bus.en = 1'b0; bus.a = 4'b0101; bus.b = 4'b0011; bus.Cin = 1'b1;
      @(posedge clk);
      #1;
      check("hold_sum_q",  {4'd0, bus.sum_q},  8'h07);
      check("hold_cout_q", {7'd0, bus.cout_q}, 8'h01);
      check_ovf("hold_ovf_q", 1'b1);
      check("hold_comb_sum",  {4'd0, bus.sum},  8'h09);
      check("hold_comb_cout", {7'd0, bus.Cout}, 8'h00);

      // Mid-cycle asynchronous reset.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_sum_q",  {4'd0, bus.sum_q},  8'h00);
      check("async_cout_q", {7'd0, bus.cout_q}, 8'h00);
      check_ovf("async_ovf_q", 1'b0);
      bus.a = 4'b0010; bus.b = 4'b0011; bus.Cin = 1'b0;
      #1;
      check("async_comb_sum",  {4'd0, bus.sum},  8'h05);
      check("async_comb_cout", {7'd0, bus.Cout}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      apply("post_rst", 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);

      // Exhaustive sweep through both the combinational and registered paths.
      for (int i = 0; i < 512; i++) begin
         logic [8:0] iv;
         logic [3:0] va, vb;
         logic       vc;
         int         us, ss;
         logic [4:0] er;
         iv = 9'(i);
         va = iv[3:0]; vb = iv[7:4]; vc = iv[8];
         us = int'(va) + int'(vb) + int'(vc);
         ss = sval(va) + sval(vb) + int'(vc);
         er = 5'(us);
         @(negedge clk);
         bus.a = va; bus.b = vb; bus.Cin = vc; bus.en = 1'b1;
         #1;
         check("sweep_comb", {3'd0, bus.Cout, bus.sum}, {3'd0, er});
         @(posedge clk);
         #1;
         check("sweep_reg", {3'd0, bus.cout_q, bus.sum_q}, {3'd0, er});
         check_ovf("sweep_ovf", (ss > 7) || (ss < -8));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ripple_carry_adder_4bit.md
RIPPLE_CARRY_ADDER_4BIT -- requirements
Module: ripple_carry_adder_4bit

Interface
REQ-001 Parameter WIDTH, default 4: adder width; only 4 is supported and verified.
REQ-002 clk  input  1  rising-edge clock for the output register stage.
REQ-003 rst_n  input  1  reset; asynchronous, active-low; one clock domain.
REQ-004 a  input  4  operand A, unsigned or two's complement.
REQ-005 b  input  4  operand B, unsigned or two's complement.
REQ-006 Cin  input  1  carry into bit 0.
REQ-007 en  input  1  register-stage load enable.
REQ-008 sum  output  4  combinational sum a+b+Cin, bits [3:0].
REQ-009 Cout  output  1  combinational carry out of bit 3.
REQ-010 sum_q  output  4  registered copy of sum.
REQ-011 cout_q  output  1  registered copy of Cout.
REQ-012 ovf_q  output  1  registered signed-overflow flag; present only per REQ-026.

Function
REQ-013 Datapath SHALL be a structural chain of four 1-bit full-adder cells; cell i carry-out drives cell i+1 carry-in; cell 0 carry-in is Cin; cell 3 carry-out is Cout.
REQ-014 Each cell SHALL compute s = x XOR y XOR ci and co = (x AND y) OR (ci AND (x XOR y)).
REQ-015 {Cout, sum} SHALL equal the 5-bit value a + b + Cin for all 512 input combinations.
REQ-016 sum and Cout SHALL be purely combinational, with zero-cycle latency and no dependence on clk, rst_n or en.
REQ-017 On a rising clk edge with rst_n=1 and en=1, sum_q, cout_q and ovf_q SHALL load sum, Cout and ovf; latency is exactly 1 cycle.
REQ-018 On a rising clk edge with en=0, the registered outputs SHALL hold their values.
REQ-019 Signed overflow ovf SHALL be the carry into bit 3 XOR the carry out of bit 3.
REQ-020 Wrap-around: a result of 16 or more SHALL set Cout=1, with sum equal to the result modulo 16; no saturation.

Reset
REQ-021 rst_n=0 SHALL immediately clear sum_q, cout_q and ovf_q to 0, independent of clk.
REQ-022 Reset SHALL NOT affect the combinational outputs sum and Cout.
REQ-023 Reset asserted during an en=1 edge SHALL win; registers stay 0.
REQ-024 After rst_n deasserts, the first rising edge with en=1 SHALL load normally.

Configuration
REQ-025 Macro RCA4_OVF_FLAG_EN controls the signed-overflow feature.
REQ-026 With RCA4_OVF_FLAG_EN defined, port ovf_q and its register SHALL exist per REQ-017/019/021.
REQ-027 Without RCA4_OVF_FLAG_EN, port ovf_q and the overflow logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-028 a=0110, b=1100, Cin=0 -> sum=0010, Cout=1, ovf=0.
REQ-029 a=1101, b=1001, Cin=1 -> sum=0111, Cout=1, ovf=1.
REQ-030 a=0101, b=0011, Cin=1 -> sum=1001, Cout=0, ovf=1; a=0010, b=0011, Cin=0 -> sum=0101, Cout=0, ovf=0.
REQ-031 a=1111, b=0001, Cin=0 -> sum=0000, Cout=1; a=1111, b=1111, Cin=1 -> sum=1111, Cout=1, ovf=0.
REQ-032 Register stage: en=1, then one clk edge -> sum_q/cout_q match the prior combinational values; en=0 with new inputs -> hold; rst_n=0 mid-cycle -> immediate 0, while sum/Cout still track the inputs.
REQ-033 Exhaustive sweep of all 512 (a, b, Cin) combinations -> {Cout, sum} equals a+b+Cin; build and run the bench both with and without RCA4_OVF_FLAG_EN.
